// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the multiply/divide sequencer.
// Holds the FSM state type, op and HI/LO source encodings, and the counter width.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    EXC   = 3'd4
  } state_t;

  localparam logic OP_MULT   = 1'b0;
  localparam logic OP_DIV    = 1'b1;
  localparam logic HILO_DIV  = 1'b0;
  localparam logic HILO_MULT = 1'b1;

  localparam int CNT_W = 6;

  // The counter is loaded with N-1 so that WAIT lasts exactly N cycles.
  function automatic logic [CNT_W-1:0] latency_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_latency_counter.sv
// Loadable 6-bit down-counter that measures the fixed mult/div unit latency.
// Stops at zero rather than wrapping.
module latency_counter
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             is_zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared mult/div unit: start pulse, fixed-latency wait,
// then a HI/LO commit or a divide-by-zero exception.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic op_valid,
  input  logic op_is_div,
  input  logic divzero,
  output logic mult_start,
  output logic div_start,
  output logic HiLoSrc,
  output logic HI_write,
  output logic LO_write,
  output logic busy,
  output logic done,
  output logic div_zero_exc
);

  localparam logic [CNT_W-1:0] MULT_LOAD = latency_load(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = latency_load(DIV_CYCLES);

  state_t           state;
  state_t           state_nx;
  logic             op_reg;
  logic             hilo_src;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_value;

  // HiLoSrc is its own register so it resets to 0 yet holds through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_reg   <= OP_MULT;
      hilo_src <= HILO_DIV;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && op_valid) begin
        op_reg   <= op_is_div;
        hilo_src <= op_is_div ? HILO_DIV : HILO_MULT;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    mult_start   = 1'b0;
    div_start    = 1'b0;
    HI_write     = 1'b0;
    LO_write     = 1'b0;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    busy         = (state != IDLE);
    HiLoSrc      = hilo_src;
    case (state)
      IDLE: begin
        if (op_valid) state_nx = START;
      end
      START: begin
        mult_start = (op_reg == OP_MULT);
        div_start  = (op_reg == OP_DIV);
        state_nx   = WAIT;
      end
      WAIT: begin
        if ((op_reg == OP_DIV) && divzero) begin
          state_nx = EXC;
        end else if (cnt_zero) begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        HI_write = 1'b1;
        LO_write = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      EXC: begin
        div_zero_exc = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cnt_load       = (state == START);
  assign cnt_dec        = (state == WAIT);
  assign cnt_load_value = (op_reg == OP_DIV) ? DIV_LOAD : MULT_LOAD;

  latency_counter u_latency_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .is_zero    (cnt_zero)
  );

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the shared multi-cycle multiply/divide resource (mult and div units, HI/LO registers, HI/LO source muxes). It accepts one operation request from the control unit, pulses the matching start line, counts the fixed unit latency, then commits the result to HI/LO, or raises a divide-by-zero exception instead. It sits between the control unit and the mult/div/HI/LO datapath. The control unit only issues a request and waits for `done` or `div_zero_exc`, instead of counting cycles itself.

## Interface
Parameters:
- MULT_CYCLES, 32, cycles the mult unit needs after its start pulse; legal range 1..63
- DIV_CYCLES, 32, cycles the div unit needs after its start pulse; legal range 1..63

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  request a new operation; sampled only in IDLE
- op_is_div  in  1  1 = div, 0 = mult; sampled together with op_valid
- divzero  in  1  divide-by-zero flag from the div unit
- mult_start  out  1  one-cycle start pulse to the mult unit
- div_start  out  1  one-cycle start pulse to the div unit
- HiLoSrc  out  1  HI/LO mux select; 1 = mult outputs, 0 = div outputs
- HI_write  out  1  HI register write enable
- LO_write  out  1  LO register write enable
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when HI/LO are written
- div_zero_exc  out  1  one-cycle pulse when a div aborts on divzero

## Operation
- State machine states: IDLE, START, WAIT, WRITE, EXC. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE:
  - If op_valid = 1, latch op_is_div into op_reg and go to START.
  - Otherwise stay in IDLE.
- START:
  - Assert mult_start (op_reg = 0) or div_start (op_reg = 1) for exactly this cycle.
  - Load the counter with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Go to WAIT.
- WAIT:
  - For a div, divzero = 1 in any WAIT cycle sends the FSM to EXC immediately, with no HI/LO write.
  - Otherwise: if counter = 0, go to WRITE; else decrement the counter.
  - divzero is ignored for mult.
- WRITE:
  - HI_write = LO_write = done = 1 for this one cycle.
  - Go to IDLE.
- EXC:
  - div_zero_exc = 1 for this one cycle.
  - HI_write and LO_write stay 0.
  - Go to IDLE.
- HiLoSrc = ~op_reg in every cycle from START through WRITE, and holds its last value in IDLE.
- op_valid is ignored in every state except IDLE. No queueing; a request made while busy is dropped.
- Counter: 6-bit unsigned. It never wraps, because the FSM leaves WAIT at 0.
- op_is_div is only meaningful while op_valid = 1.

## Timing
- Reset (sync, wins over every other input in the same cycle):
  - state = IDLE, op_reg = 0, counter = 0.
  - All outputs 0, including HiLoSrc = 0 and busy = 0.
- Reset during any state aborts the operation. No HI/LO write, done or exception follows.
- Latency, with op_valid sampled at edge 0:
  - start pulse in cycle 1.
  - WAIT occupies cycles 2..(1+N), where N = MULT_CYCLES or DIV_CYCLES.
  - done / HI_write / LO_write in cycle 2+N.
  - busy drops in cycle 3+N.
- Minimum spacing between two accepted requests is N+3 cycles. A new op_valid is accepted at the first edge where state = IDLE, i.e. the cycle in which busy is already 0.
- Divide-by-zero: divzero seen high in WAIT cycle k gives div_zero_exc in cycle k+1, and busy = 0 in cycle k+2.
- done and div_zero_exc are mutually exclusive and never high in the same cycle.

## Structure
- Shared package muldiv_pkg holds:
  - the state typedef (IDLE, START, WAIT, WRITE, EXC);
  - the op encoding constants OP_MULT = 0, OP_DIV = 1;
  - the HiLoSrc encoding constants HILO_DIV = 0, HILO_MULT = 1.
- One sub-module, latency_counter: 6-bit loadable down-counter with load, load_value and an is_zero output. muldiv_ctrl contains only the FSM and the output decode.

## Test plan
- Mult, MULT_CYCLES = 32: op_valid = 1 and op_is_div = 0 at cycle 0. Expect mult_start in cycle 1; HI_write = LO_write = done = 1 with HiLoSrc = 1 in cycle 34; busy = 0 in cycle 35; div_start never asserted.
- Div, DIV_CYCLES = 32, divzero = 0: expect div_start in cycle 1; done in cycle 34 with HiLoSrc = 0; div_zero_exc never asserted.
- Div with divzero = 1 in cycle 2: expect div_zero_exc in cycle 3, no HI_write/LO_write at any point, busy = 0 in cycle 4.
- Request while busy: during a mult, pulse op_valid = 1 with op_is_div = 1 in cycle 10. Expect no div_start and exactly one done, in cycle 34. Then a request at cycle 35 is accepted, with its start pulse in cycle 36.
- Reset mid-operation: assert reset in cycle 15 of a div. Expect all outputs 0 from cycle 16, no done or exception afterwards, and a fresh mult request still completing in MULT_CYCLES + 2 cycles.
- Boundary parameters: MULT_CYCLES = 1 gives done in cycle 3; also run MULT_CYCLES = 63 with the counter not wrapping. Also hold divzero = 1 throughout a mult: expect normal completion.
